// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the neural-net phase sequencer.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_BWD  = 3'd2,
        ST_UPD  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic MODE_TRAIN = 1'b1;
    localparam logic MODE_VALID = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nn_phase_seq_if.sv
// Control/status bundle between the run controller and the phase sequencer.
interface nn_phase_seq_if #(
    parameter int NUM_LAYERS = 2,
    parameter int BATCH_W    = 8
);
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                  start;
    logic                  mode;
    logic [BATCH_W-1:0]    batch_len;
    logic                  abort;
    logic                  busy;
    logic [NUM_LAYERS-1:0] fwd_en;
    logic [NUM_LAYERS-1:0] bwd_en;
    logic                  upd_en;
    logic [LW-1:0]         layer_idx;
    logic [BATCH_W-1:0]    sample_idx;
    logic                  sample_done;
    logic                  done;

    modport master (
        output start, mode, batch_len, abort,
        input  busy, fwd_en, bwd_en, upd_en, layer_idx, sample_idx, sample_done, done
    );

    modport slave (
        input  start, mode, batch_len, abort,
        output busy, fwd_en, bwd_en, upd_en, layer_idx, sample_idx, sample_done, done
    );

endinterface

// File: rtl/nn_phase_timer.sv
// Loadable cycle counter; expired is high while the count equals the limit.
module nn_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] count_r;

    // Count up each cycle, restarting from zero on every phase boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_r + W'(1'b1);
        end
    end

    assign count   = count_r;
    assign expired = (count_r == limit);

endmodule

// File: rtl/nn_phase_seq.sv
// Phase sequencer: per-layer forward/backward enables, batch loop and weight update.
module nn_phase_seq
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int FP_CYC     = 18,
    parameter int BP_CYC     = 16,
    parameter int UPD_CYC    = 8,
    parameter int BATCH_W    = 8
) (
    input logic           clk,
    input logic           rst_n,
    nn_phase_seq_if.slave bus
);

    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CW = $clog2(max3(FP_CYC, BP_CYC, UPD_CYC) + 1);
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [LW-1:0] FIRST_LAYER = {LW{1'b0}};

    if (NUM_LAYERS < 1) begin : g_bad_layers
        $error("nn_phase_seq: NUM_LAYERS must be at least 1");
    end
    if ((FP_CYC < 1) || (BP_CYC < 1) || (UPD_CYC < 1)) begin : g_bad_cyc
        $error("nn_phase_seq: FP_CYC, BP_CYC and UPD_CYC must be at least 1");
    end

    state_e                state_r;
    logic                  mode_r;
    logic [BATCH_W-1:0]    len_r;
    logic [BATCH_W-1:0]    sample_r;
    logic [LW-1:0]         layer_r;
    logic [NUM_LAYERS-1:0] fwd_en_r;
    logic [NUM_LAYERS-1:0] bwd_en_r;
    logic                  upd_en_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  sample_done_r;

    logic [CW-1:0]         count_s;
    logic [CW-1:0]         limit_s;
    logic                  expired_s;
    logic                  load_s;
    logic                  sample_end_s;
    logic                  more_samples_s;
    logic                  last_next_s;
    logic [LW-1:0]         layer_inc_s;
    logic [LW-1:0]         layer_dec_s;

    function automatic logic is_final(input state_e st, input logic [LW-1:0] lyr, input logic md);
        return ((st == ST_FWD) && (lyr == LAST_LAYER) && (md == MODE_VALID)) ||
               ((st == ST_BWD) && (lyr == FIRST_LAYER));
    endfunction

    function automatic logic one_cycle(input state_e st);
        return ((st == ST_FWD) && (FP_CYC == 1)) || ((st == ST_BWD) && (BP_CYC == 1));
    endfunction

    function automatic logic [NUM_LAYERS-1:0] onehot(input logic [LW-1:0] lyr);
        return NUM_LAYERS'(1'b1) << lyr;
    endfunction

    // Terminal count of the phase currently being held
    always_comb begin
        case (state_r)
            ST_FWD:  limit_s = CW'(FP_CYC - 1);
            ST_BWD:  limit_s = CW'(BP_CYC - 1);
            ST_UPD:  limit_s = CW'(UPD_CYC - 1);
            default: limit_s = {CW{1'b0}};
        endcase
    end

    assign load_s         = (state_r == ST_IDLE) || (state_r == ST_DONE) || expired_s;
    assign layer_inc_s    = layer_r + LW'(1'b1);
    assign layer_dec_s    = layer_r - LW'(1'b1);
    assign sample_end_s   = expired_s && is_final(state_r, layer_r, mode_r);
    assign more_samples_s = ({1'b0, sample_r} + {{BATCH_W{1'b0}}, 1'b1}) < {1'b0, len_r};
    // sample_done is registered, so it is raised one cycle before the final phase's last cycle
    assign last_next_s    = is_final(state_r, layer_r, mode_r) &&
                            (({1'b0, count_s} + {{CW{1'b0}}, 1'b1}) == {1'b0, limit_s});

    nn_phase_timer #(.W(CW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .limit   (limit_s),
        .count   (count_s),
        .expired (expired_s)
    );

    // Sequencing FSM; every output is updated on the edge that enters its state
    always_ff @(posedge clk) begin
        if (!rst_n || bus.abort) begin
            state_r       <= ST_IDLE;
            mode_r        <= MODE_VALID;
            len_r         <= {BATCH_W{1'b0}};
            sample_r      <= {BATCH_W{1'b0}};
            layer_r       <= FIRST_LAYER;
            fwd_en_r      <= {NUM_LAYERS{1'b0}};
            bwd_en_r      <= {NUM_LAYERS{1'b0}};
            upd_en_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            sample_done_r <= 1'b0;
        end else begin
            done_r        <= 1'b0;
            sample_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_r        <= bus.mode;
                        len_r         <= (bus.batch_len == {BATCH_W{1'b0}}) ? BATCH_W'(1'b1) : bus.batch_len;
                        sample_r      <= {BATCH_W{1'b0}};
                        layer_r       <= FIRST_LAYER;
                        state_r       <= ST_FWD;
                        busy_r        <= 1'b1;
                        fwd_en_r      <= onehot(FIRST_LAYER);
                        sample_done_r <= is_final(ST_FWD, FIRST_LAYER, bus.mode) && one_cycle(ST_FWD);
                    end
                end
                ST_FWD, ST_BWD: begin
                    if (!expired_s) begin
                        sample_done_r <= last_next_s;
                    end else if (sample_end_s) begin
                        fwd_en_r <= {NUM_LAYERS{1'b0}};
                        bwd_en_r <= {NUM_LAYERS{1'b0}};
                        layer_r  <= FIRST_LAYER;
                        if (more_samples_s) begin
                            state_r       <= ST_FWD;
                            sample_r      <= sample_r + BATCH_W'(1'b1);
                            fwd_en_r      <= onehot(FIRST_LAYER);
                            sample_done_r <= is_final(ST_FWD, FIRST_LAYER, mode_r) && one_cycle(ST_FWD);
                        end else if (mode_r == MODE_TRAIN) begin
                            state_r  <= ST_UPD;
                            upd_en_r <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else if ((state_r == ST_FWD) && (layer_r != LAST_LAYER)) begin
                        layer_r       <= layer_inc_s;
                        fwd_en_r      <= onehot(layer_inc_s);
                        sample_done_r <= is_final(ST_FWD, layer_inc_s, mode_r) && one_cycle(ST_FWD);
                    end else if (state_r == ST_FWD) begin
                        state_r       <= ST_BWD;
                        fwd_en_r      <= {NUM_LAYERS{1'b0}};
                        bwd_en_r      <= onehot(LAST_LAYER);
                        sample_done_r <= is_final(ST_BWD, LAST_LAYER, mode_r) && one_cycle(ST_BWD);
                    end else begin
                        layer_r       <= layer_dec_s;
                        bwd_en_r      <= onehot(layer_dec_s);
                        sample_done_r <= is_final(ST_BWD, layer_dec_s, mode_r) && one_cycle(ST_BWD);
                    end
                end
                ST_UPD: begin
                    if (expired_s) begin
                        state_r  <= ST_DONE;
                        upd_en_r <= 1'b0;
                        done_r   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    sample_r <= {BATCH_W{1'b0}};
                    layer_r  <= FIRST_LAYER;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    fwd_en_r <= {NUM_LAYERS{1'b0}};
                    bwd_en_r <= {NUM_LAYERS{1'b0}};
                    upd_en_r <= 1'b0;
                    sample_r <= {BATCH_W{1'b0}};
                    layer_r  <= FIRST_LAYER;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.fwd_en      = fwd_en_r;
    assign bus.bwd_en      = bwd_en_r;
    assign bus.upd_en      = upd_en_r;
    assign bus.layer_idx   = layer_r;
    assign bus.sample_idx  = sample_r;
    assign bus.sample_done = sample_done_r;
    assign bus.done        = done_r;

endmodule

// File: tb/tb_nn_phase_seq.sv
// Bench for nn_phase_seq: two configurations against a per-cycle trace model.
module tb_nn_phase_seq;

    localparam int A_L = 2, A_F = 18, A_B = 16, A_U = 8;
    localparam int B_L = 4, B_F = 2,  B_B = 1,  B_U = 1;

    typedef struct packed {
        logic       busy;
        logic [3:0] fwd;
        logic [3:0] bwd;
        logic       upd;
        logic [1:0] lidx;
        logic [7:0] sidx;
        logic       sdone;
        logic       done;
    } obs_t;

    typedef struct {
        int         w;
        logic       md;
        logic [7:0] ln;
        int         ab;
        int         lat;
    } vec_t;

    localparam obs_t IDLE_OBS = '0;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    nn_phase_seq_if #(.NUM_LAYERS(A_L), .BATCH_W(8)) ia ();
    nn_phase_seq_if #(.NUM_LAYERS(B_L), .BATCH_W(8)) ib ();

    nn_phase_seq #(.NUM_LAYERS(A_L), .FP_CYC(A_F), .BP_CYC(A_B), .UPD_CYC(A_U), .BATCH_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    nn_phase_seq #(.NUM_LAYERS(B_L), .FP_CYC(B_F), .BP_CYC(B_B), .UPD_CYC(B_U), .BATCH_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    function automatic obs_t get_obs(input int w);
        obs_t o;
        o = '0;
        if (w == 0) begin
            o.busy = ia.busy; o.fwd = 4'(ia.fwd_en); o.bwd = 4'(ia.bwd_en); o.upd = ia.upd_en;
            o.lidx = 2'(ia.layer_idx); o.sidx = ia.sample_idx; o.sdone = ia.sample_done; o.done = ia.done;
        end else begin
            o.busy = ib.busy; o.fwd = 4'(ib.fwd_en); o.bwd = 4'(ib.bwd_en); o.upd = ib.upd_en;
            o.lidx = 2'(ib.layer_idx); o.sidx = ib.sample_idx; o.sdone = ib.sample_done; o.done = ib.done;
        end
        return o;
    endfunction

    task automatic drive(input int w, input logic s, input logic m, input logic [7:0] l, input logic a);
        if (w == 0) begin
            ia.start = s; ia.mode = m; ia.batch_len = l; ia.abort = a;
        end else begin
            ib.start = s; ib.mode = m; ib.batch_len = l; ib.abort = a;
        end
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected per-cycle outputs of a whole run, listed phase by phase
    task automatic build_trace(input int nl, input int fp, input int bp, input int up,
                               input logic md, input logic [7:0] ln);
        int   eff;
        obs_t o;
        exp_q = {};
        eff = (ln == 8'd0) ? 1 : int'(ln);
        for (int s = 0; s < eff; s++) begin
            for (int l = 0; l < nl; l++)
                for (int c = 0; c < fp; c++) begin
                    o = '0; o.busy = 1'b1; o.fwd = 4'(1 << l); o.lidx = 2'(l); o.sidx = 8'(s);
                    exp_q.push_back(o);
                end
            if (md)
                for (int l = nl - 1; l >= 0; l--)
                    for (int c = 0; c < bp; c++) begin
                        o = '0; o.busy = 1'b1; o.bwd = 4'(1 << l); o.lidx = 2'(l); o.sidx = 8'(s);
                        exp_q.push_back(o);
                    end
            exp_q[exp_q.size() - 1].sdone = 1'b1;
        end
        if (md)
            for (int c = 0; c < up; c++) begin
                o = '0; o.busy = 1'b1; o.upd = 1'b1; o.sidx = 8'(eff - 1);
                exp_q.push_back(o);
            end
        o = '0; o.busy = 1'b1; o.done = 1'b1; o.sidx = 8'(eff - 1);
        exp_q.push_back(o);
    endtask

    task automatic run(input int id, input int w, input logic md, input logic [7:0] ln,
                       input int ab, input int lat);
        obs_t o;
        int   busy_n;
        int   n;
        if (w == 0) build_trace(A_L, A_F, A_B, A_U, md, ln);
        else        build_trace(B_L, B_F, B_B, B_U, md, ln);
        n = exp_q.size();
        busy_n = 0;
        @(negedge clk);
        drive(w, 1'b1, md, ln, 1'b0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            o = get_obs(w);
            check($sformatf("run%0d_cyc%0d", id, k + 1), o, exp_q[k]);
            if (o.busy) busy_n++;
            if (k == ab) begin
                drive(w, 1'(($urandom & 1)), ~md, 8'($urandom), 1'b1);
                @(negedge clk);
                check($sformatf("run%0d_abort", id), get_obs(w), IDLE_OBS);
                drive(w, 1'b0, md, ln, 1'b0);
                break;
            end
            drive(w, 1'(($urandom & 1)), 1'(($urandom & 1)), 8'($urandom), 1'b0);
        end
        @(negedge clk);
        check($sformatf("run%0d_idle", id), get_obs(w), IDLE_OBS);
        drive(w, 1'b0, md, ln, 1'b0);
        if (ab < 0) check_int($sformatf("run%0d_latency", id), busy_n, lat);
    endtask

    initial begin
        obs_t o;
        int   found;
        int   w, lat, ab, eff;
        logic md;
        logic [7:0] ln;

        tbl[0] = '{0, 1'b1, 8'd1, -1, 77};
        tbl[1] = '{0, 1'b0, 8'd3, -1, 109};
        tbl[2] = '{1, 1'b1, 8'd2, -1, 26};
        tbl[3] = '{0, 1'b1, 8'd0, -1, 77};
        tbl[4] = '{1, 1'b0, 8'd0, -1, 9};
        tbl[5] = '{0, 1'b1, 8'd2, 60, 0};
        tbl[6] = '{0, 1'b1, 8'd1, -1, 77};
        tbl[7] = '{1, 1'b1, 8'd1, -1, 14};

        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 8'd1, 1'b0);
        drive(1, 1'b1, 1'b1, 8'd1, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_a", get_obs(0), IDLE_OBS);
        check("reset_b", get_obs(1), IDLE_OBS);
        drive(0, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_a", get_obs(0), IDLE_OBS);
        check("idle_b", get_obs(1), IDLE_OBS);

        for (int i = 0; i < 8; i++)
            run(i, tbl[i].w, tbl[i].md, tbl[i].ln, tbl[i].ab, tbl[i].lat);

        // Synchronous reset while the weight update is in progress
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'd1, 1'b0);
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b1, 8'd1, 1'b0);
            o = get_obs(0);
            if (o.upd) found = 1;
        end
        check_int("reach_upd", found, 1);
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 8'd1, 1'b0);
        @(negedge clk);
        check("reset_in_upd", get_obs(0), IDLE_OBS);
        drive(0, 1'b0, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", get_obs(0), IDLE_OBS);

        for (int i = 0; i < 10; i++) begin
            w   = int'($urandom_range(0, 1));
            md  = 1'($urandom_range(0, 1));
            ln  = 8'($urandom_range(0, 3));
            eff = (ln == 8'd0) ? 1 : int'(ln);
            if (w == 0) lat = md ? eff * A_L * (A_F + A_B) + A_U + 1 : eff * A_L * A_F + 1;
            else        lat = md ? eff * B_L * (B_F + B_B) + B_U + 1 : eff * B_L * B_F + 1;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
            run(100 + i, w, md, ln, ab, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
